// File: rtl/cache_axi_bridge_pkg.sv
// Shared types and constants for the D-cache to AXI4 bridge.
package cache_axi_bridge_pkg;

  // Cache transfer-size encodings carried on rd_type / wr_type.
  typedef enum logic [2:0] {
    TYPE_BYTE  = 3'b000,
    TYPE_HALF  = 3'b001,
    TYPE_WORD  = 3'b010,
    TYPE_DWORD = 3'b011,
    TYPE_LINE  = 3'b100
  } xfer_type_e;

  localparam int LINE_BEATS  = 2;
  localparam int OFFSET_BITS = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BUSY,
    W_RESP
  } wr_state_e;

  function automatic logic is_line(input logic [2:0] t);
    return t == TYPE_LINE;
  endfunction

  // Line transfers start on the line boundary; single accesses keep their address.
  function automatic logic [31:0] axi_addr(input logic [2:0] t, input logic [31:0] a);
    return is_line(t) ? {a[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : a;
  endfunction

  function automatic logic [7:0] axi_len(input logic [2:0] t);
    return is_line(t) ? 8'(LINE_BEATS - 1) : 8'd0;
  endfunction

  function automatic logic [2:0] axi_size(input logic [2:0] t);
    return is_line(t) ? 3'd3 : {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI4 master bus of the bridge: AR/R/AW/W/B channels, 64-bit data.
interface cache_axi_bridge_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/cache_axi_wr_ch.sv
// Write channel: accepts one cache write, issues AW and W concurrently, waits for B.
module cache_axi_wr_ch
  import cache_axi_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [7:0]   wr_wstb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         busy,
  output logic [27:0]  line,
  output logic         resp_err,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         wvalid,
  input  logic         wready,
  output logic [63:0]  wdata,
  output logic [7:0]   wstrb,
  output logic         wlast,
  input  logic         bvalid,
  input  logic [1:0]   bresp,
  output logic         bready
);

  wr_state_e      state;
  logic           line_q;
  logic [7:0]     strb_q;
  logic [127:0]   data_q;
  logic           beat;
  logic           aw_done;
  logic           w_done;

  // A channel counts as finished if its valid already dropped or it handshakes now.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || (wready && wlast);

  assign wr_rdy   = (state == W_IDLE);
  assign busy     = (state != W_IDLE);
  assign line     = awaddr[31:OFFSET_BITS];
  assign resp_err = bvalid && bready && (bresp != RESP_OKAY);

  assign wdata = beat ? data_q[127:64] : data_q[63:0];
  assign wstrb = line_q ? 8'hFF : strb_q;
  assign wlast = line_q ? (beat == 1'(LINE_BEATS - 1)) : 1'b1;

  // Write FSM: latch request, run AW and W independently, then collect B.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data/strobe holding registers are reset too, so wdata and the
      // address outputs read 0 while in reset rather than stale garbage.
      state   <= W_IDLE;
      line_q  <= 1'b0;
      strb_q  <= '0;
      data_q  <= '0;
      beat    <= 1'b0;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      awsize  <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      // NOTE: all state updates are non-blocking so every register samples
      // pre-edge values and the block order does not matter.
      case (state)
        W_IDLE: begin
          if (wr_req) begin
            awaddr  <= axi_addr(wr_type, wr_addr);
            awlen   <= axi_len(wr_type);
            awsize  <= axi_size(wr_type);
            line_q  <= is_line(wr_type);
            strb_q  <= wr_wstb;
            data_q  <= wr_data;
            beat    <= 1'b0;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) begin
            if (wlast) wvalid <= 1'b0;
            else       beat   <= beat + 1'b1;
          end
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= W_IDLE;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// D-cache miss/writeback port to AXI4 master: read FSM here, write channel in a sub-module.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [2:0]          rd_type,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic                ret_last,
  output logic [63:0]         ret_data,
  input  logic                wr_req,
  input  logic [2:0]          wr_type,
  input  logic [31:0]         wr_addr,
  input  logic [7:0]          wr_wstb,
  input  logic [127:0]        wr_data,
  output logic                wr_rdy,
  output logic                bus_err,
  cache_axi_bridge_if.master  axi
);

  rd_state_e   rd_state;
  logic        ar_valid_q;
  logic [31:0] ar_addr_q;
  logic [7:0]  ar_len_q;
  logic [2:0]  ar_size_q;
  logic        wr_busy;
  logic [27:0] wr_line;
  logic        wr_resp_err;
  logic        hazard;

  // A read may not overtake a write to the same line, including one accepted this cycle.
  assign hazard = (wr_busy && (rd_addr[31:OFFSET_BITS] == wr_line)) ||
                  (wr_req && wr_rdy && (rd_addr[31:OFFSET_BITS] == wr_addr[31:OFFSET_BITS]));

  assign rd_rdy    = (rd_state == R_IDLE) && !hazard;
  assign axi.rready = (rd_state == R_DATA);
  assign ret_valid = axi.rready && axi.rvalid;
  assign ret_last  = ret_valid && axi.rlast;
  assign ret_data  = ret_valid ? axi.rdata : '0;

  assign axi.arvalid = ar_valid_q;
  assign axi.araddr  = ar_addr_q;
  assign axi.arlen   = ar_len_q;
  assign axi.arsize  = ar_size_q;
  assign axi.arid    = AXI_ID;
  assign axi.arburst = BURST_INCR;
  assign axi.awid    = AXI_ID;
  assign axi.awburst = BURST_INCR;

  // Read FSM: latch request, present AR until accepted, pass R beats until rlast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state   <= R_IDLE;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            ar_addr_q  <= axi_addr(rd_type, rd_addr);
            ar_len_q   <= axi_len(rd_type);
            ar_size_q  <= axi_size(rd_type);
            ar_valid_q <= 1'b1;
            rd_state   <= R_AR;
          end
        end
        R_AR: begin
          if (axi.arready) begin
            ar_valid_q <= 1'b0;
            rd_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.rvalid && axi.rlast) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Sticky error flag for any non-OKAY read or write response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else if ((ret_valid && (axi.rresp != RESP_OKAY)) || wr_resp_err) begin
      bus_err <= 1'b1;
    end
  end

  cache_axi_wr_ch u_wr_ch (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstb  (wr_wstb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .busy     (wr_busy),
    .line     (wr_line),
    .resp_err (wr_resp_err),
    .awvalid  (axi.awvalid),
    .awready  (axi.awready),
    .awaddr   (axi.awaddr),
    .awlen    (axi.awlen),
    .awsize   (axi.awsize),
    .wvalid   (axi.wvalid),
    .wready   (axi.wready),
    .wdata    (axi.wdata),
    .wstrb    (axi.wstrb),
    .wlast    (axi.wlast),
    .bvalid   (axi.bvalid),
    .bresp    (axi.bresp),
    .bready   (axi.bready)
  );

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

- Converts the D-cache miss/writeback interface into AXI4 master transactions on a 64-bit bus.
- Sits directly downstream of the data cache:
  - accepts one read request (single access or 16 B line refill) and one write request (single access or 16 B line writeback);
  - returns read beats to the cache.
- Read and write channels run independently, except for a same-line read-after-write interlock.

## Interface
- `AXI_ID`, default 0 — constant ARID/AWID driven on every transaction.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `rd_req`  in  1  — cache read request.
- `rd_type`  in  3  — 000 byte, 001 half, 010 word, 011 dword, 100 cache line.
- `rd_addr`  in  32  — read start address.
- `rd_rdy`  out  1  — read request accepted this cycle when high with `rd_req`.
- `ret_valid`  out  1  — `ret_data` valid.
- `ret_last`  out  1  — final beat of current read.
- `ret_data`  out  64  — returned data beat.
- `wr_req`  in  1  — cache write request.
- `wr_type`  in  3  — encoding as `rd_type`.
- `wr_addr`  in  32  — write address.
- `wr_wstb`  in  8  — byte strobes for non-line writes.
- `wr_data`  in  128  — line data; `[63:0]` is beat 0, `[127:64]` beat 1. Non-line uses `[63:0]`.
- `wr_rdy`  out  1  — write request accepted when high with `wr_req`.
- `bus_err`  out  1  — sticky; set on any RRESP/BRESP ≠ OKAY.
- AXI AR channel: `arvalid` out 1, `arready` in 1, `araddr` out 32, `arid` out 4, `arlen` out 8, `arsize` out 3, `arburst` out 2.
- AXI R channel: `rvalid` in 1, `rready` out 1, `rdata` in 64, `rresp` in 2, `rlast` in 1.
- AXI AW channel: `awvalid` out 1, `awready` in 1, `awaddr` out 32, `awid` out 4, `awlen` out 8, `awsize` out 3, `awburst` out 2.
- AXI W channel: `wvalid` out 1, `wready` in 1, `wdata` out 64, `wstrb` out 8, `wlast` out 1.
- AXI B channel: `bvalid` in 1, `bready` out 1, `bresp` in 2.

## Operation
- **Read FSM** (R_IDLE → R_AR → R_DATA → R_IDLE):
  - `rd_rdy` = R_IDLE and no line hazard.
  - Accept: latch address and type, go R_AR.
  - R_AR: `arvalid`=1 until `arready`, then R_DATA.
  - R_DATA: `rready`=1. Each `rvalid` beat passes through combinationally to `ret_valid`/`ret_data`/`ret_last` (`ret_last`=`rlast`).
  - Return to R_IDLE on the `rlast` handshake.
- **Write FSM** (W_IDLE → W_BUSY → W_RESP → W_IDLE):
  - `wr_rdy` = W_IDLE.
  - Accept: latch address, type, strobes, 128-bit data; go W_BUSY.
  - W_BUSY: AW and W are driven concurrently and independently; either may complete first. `awvalid` drops after its handshake; W beats advance on a 1-bit beat counter.
  - After both the AW and the final W handshakes → W_RESP. `bready`=1; `bvalid` → W_IDLE.
- **Line transfer** (type 100): address aligned to `{addr[31:4],4'b0}`, len=1, size=3, burst INCR. Write strobes are 8'hFF on both beats; `wlast` on beat 1.
- **Non-line transfer**: address unmodified, len=0, size=`type[1:0]`, burst INCR. `wstrb`=`wr_wstb`, `wlast`=1.
- **Hazard**: `rd_rdy` is forced low when `rd_addr[31:4]` equals the line of a write in W_BUSY/W_RESP. It is also forced low when it matches a write being accepted in the same cycle (`wr_req && wr_rdy`). The read waits until the write reaches W_IDLE.
- **Errors**: a non-OKAY response sets `bus_err` until reset. The transaction still completes normally; data is passed through unchanged.

## Timing
- **Reset**: asynchronous, all outputs 0 immediately — valids, `rready`, `bready`, `ret_*`, `bus_err`, `araddr`/`awaddr`/`wdata`. `rd_rdy` and `wr_rdy` read 1 after reset release (idle FSMs).
- Reset mid-burst abandons the transaction; the FSMs restart in IDLE.
- Request accepted at edge T ⇒ `arvalid`/`awvalid`/`wvalid` high from cycle T+1.
- Read data latency: zero cycles from `rvalid` to `ret_valid`.
- AR/AW/W valids stay high and their payloads stay stable until the corresponding ready is seen. A valid never depends on its ready.
- One outstanding read plus one outstanding write maximum. A new request may be accepted in the cycle after the completing R/B handshake.
- `rd_req` and `wr_req` to different lines in the same cycle: both are accepted.

## Structure
- **Shared package**:
  - transfer-type encodings (TYPE_BYTE..TYPE_LINE);
  - LINE_BEATS=2, OFFSET_BITS=4;
  - AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00;
  - read and write FSM state encodings.
- **Sub-module**: one natural sub-module, `cache_axi_wr_ch` (write FSM, AW/W/B handling, beat counter). Read FSM and hazard compare stay in the top.

## Test plan
- **Line read**: `rd_type`=100, `rd_addr`=0x8000_1234, `arready` delayed 2 cycles → `araddr`=0x8000_1230, `arlen`=1, `arsize`=3. Two `ret_valid` beats; `ret_last` only on the second.
- **Word read**: `rd_type`=010, addr 0x8000_0006 → `araddr`=0x8000_0006, `arlen`=0, `arsize`=2, one beat with `ret_last`=1.
- **Line write**: `wr_data`=0x1111…_2222… → beats 0x2222… then 0x1111…, `wstrb`=FF, `wlast` on beat 1.
  - Run once with W ready before AW and once with AW ready before W; both complete.
  - `wr_rdy` returns high the cycle after `bvalid`.
- **Hazard**: write to line 0x8000_0040 outstanding, read request to 0x8000_0048 → `rd_rdy`=0 until after `bvalid`. A read to 0x8000_0080 in the same window is accepted at once.
- **Error**: `rresp`=2'b10 on a read → `bus_err`=1 and stays 1 through later OKAY transactions.
- **Reset mid-burst**: assert `rst`=0 between line read beats → `rready`, `ret_valid`, `arvalid`, `bus_err` all drop to 0 asynchronously. `rd_rdy`=1 after release.
